// File: rtl/mips32_shift_seq_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mips32_shift_seq_if
// Purpose  : Request/response bundle of the multi-cycle shift sequencer.
//            master drives the request side, slave is the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface mips32_shift_seq_if #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5,
   parameter int RTAG_W  = 5
);
   logic               start;
   logic [1:0]         op;
   logic [WIDTH-1:0]   operand;
   logic [SHAMT_W-1:0] shamt;
   logic [RTAG_W-1:0]  dest;
   logic               flush;
   logic               busy;
   logic               stall;
   logic               done;
   logic [WIDTH-1:0]   result;
   logic [RTAG_W-1:0]  result_dest;

   modport master (
      output start, op, operand, shamt, dest, flush,
      input  busy, stall, done, result, result_dest
   );

   modport slave (
      input  start, op, operand, shamt, dest, flush,
      output busy, stall, done, result, result_dest
   );
endinterface

`default_nettype wire

// File: rtl/mips32_shift_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mips32_shift_seq
// Purpose  : Multi-cycle SLL/SRL/SRA sequencer, one bit per cycle, with
//            start/busy/done handshake, pipeline stall request and flush.
// Revision : 1.0 - initial release
// ============================================================================
module mips32_shift_seq #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5,
   parameter int RTAG_W  = 5
) (
   input  wire logic          clk,
   input  wire logic          reset,
   mips32_shift_seq_if.slave  bus
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [1:0] C_OP_SLL  = 2'b00;
   localparam logic [1:0] C_OP_SRL  = 2'b01;
   localparam logic [1:0] C_OP_SRA  = 2'b10;
   localparam logic [1:0] C_OP_PASS = 2'b11;

   state_t             r_state;
   state_t             w_next;
   logic [WIDTH-1:0]   r_work;
   logic [WIDTH-1:0]   w_shifted;
   logic [WIDTH-1:0]   r_result;
   logic [RTAG_W-1:0]  r_tag;
   logic [RTAG_W-1:0]  r_result_dest;
   logic [SHAMT_W-1:0] r_cnt;
   logic [1:0]         r_op;
   logic               w_accept;
   logic               w_deliver;

   // A request is taken only from IDLE and only when not being cancelled.
   assign w_accept  = (r_state == S_IDLE) & bus.start & ~bus.flush;
   // A flush during the DONE cycle suppresses delivery entirely.
   assign w_deliver = (r_state == S_DONE) & ~bus.flush;

   // One-bit shift of the working register for the captured operation.
   always_comb begin
      w_shifted = r_work;
      case (r_op)
         C_OP_SLL: w_shifted = {r_work[WIDTH-2:0], 1'b0};
         C_OP_SRL: w_shifted = {1'b0, r_work[WIDTH-1:1]};
         C_OP_SRA: w_shifted = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
         default:  w_shifted = r_work;
      endcase
   end

   // Next-state logic; flush always wins and returns to IDLE.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept)
               w_next = (bus.shamt == '0 || bus.op == C_OP_PASS) ? S_DONE : S_RUN;
         end
         S_RUN: begin
            if (bus.flush)
               w_next = S_IDLE;
            else if (r_cnt == SHAMT_W'(1))
               w_next = S_DONE;
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   // Operand capture, per-cycle shift/count, and commit of the held result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_work        <= '0;
         r_tag         <= '0;
         r_op          <= '0;
         r_cnt         <= '0;
         r_result      <= '0;
         r_result_dest <= '0;
      end else begin
         if (w_accept) begin
            r_work <= bus.operand;
            r_tag  <= bus.dest;
            r_op   <= bus.op;
            r_cnt  <= bus.shamt;
         end else if (r_state == S_RUN && !bus.flush) begin
            r_work <= w_shifted;
            r_cnt  <= r_cnt - SHAMT_W'(1);
         end
         if (w_deliver) begin
            r_result      <= r_work;
            r_result_dest <= r_tag;
         end
      end
   end

   // During an unflushed DONE cycle the fresh value is presented straight
   // from the working register; the held copy is committed on leaving DONE.
   // This keeps result stable from the DONE cycle onward while letting a
   // flush in DONE leave the previously delivered result untouched.
   assign bus.result      = w_deliver ? r_work : r_result;
   assign bus.result_dest = w_deliver ? r_tag  : r_result_dest;
   assign bus.done        = w_deliver;
   assign bus.busy        = (r_state != S_IDLE);
   assign bus.stall       = (r_state != S_IDLE) | (bus.start & ~bus.flush);
endmodule

`default_nettype wire

// File: tb/tb_mips32_shift_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mips32_shift_seq
// Purpose  : Self-checking bench for mips32_shift_seq: directed scenarios
//            plus randomized operations against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips32_shift_seq;
   localparam int WIDTH   = 32;
   localparam int SHAMT_W = 5;
   localparam int RTAG_W  = 5;

   logic        clk = 1'b0;
   logic        reset;
   int          n_checks = 0;
   int          n_errors = 0;
   int          done_cnt = 0;
   logic [31:0] last_done_res  = '0;
   logic [31:0] last_done_dest = '0;
   logic [31:0] exp_held = '0;

   mips32_shift_seq_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W), .RTAG_W(RTAG_W)) bus ();

   mips32_shift_seq #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W), .RTAG_W(RTAG_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Count every done pulse and remember what it delivered.
   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         done_cnt++;
         last_done_res  = bus.result;
         last_done_dest = 32'(bus.result_dest);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: the whole shift as one arithmetic operation.
   function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] v,
                                         input logic [4:0] s);
      case (o)
         2'b00:   return v << s;
         2'b01:   return v >> s;
         2'b10:   return 32'($signed(v) >>> s);
         default: return v;
      endcase
   endfunction

   task automatic drive_idle();
      bus.start   = 1'b0;
      bus.flush   = 1'b0;
      bus.op      = 2'b00;
      bus.operand = '0;
      bus.shamt   = '0;
      bus.dest    = '0;
   endtask

   // Called just after a rising edge with the DUT idle; returns just after
   // the rising edge that ends the DONE cycle.
   task automatic run_op(input logic [1:0] o, input logic [31:0] v, input logic [4:0] s,
                         input logic [4:0] d, output logic [31:0] res);
      int          exp_lat;
      int          lat;
      logic        busy_bad;
      logic        stall_bad;
      logic [31:0] exp_res;
      exp_res = model(o, v, s);
      exp_lat = (o == 2'b11 || s == 5'd0) ? 1 : int'(s) + 1;
      res     = '0;
      bus.start = 1'b1; bus.op = o; bus.operand = v; bus.shamt = s; bus.dest = d;
      @(negedge clk);
      check("idle_busy",   32'(bus.busy),  32'd0);
      check("start_stall", 32'(bus.stall), 32'd1);
      check("idle_done",   32'(bus.done),  32'd0);
      check("held_result", bus.result,     exp_held);
      @(posedge clk); #1;
      bus.start = 1'b0; bus.operand = $urandom; bus.dest = 5'($urandom_range(0, 31));
      lat = 0; busy_bad = 1'b0; stall_bad = 1'b0;
      for (int c = 1; c <= 40 && lat == 0; c++) begin
         @(negedge clk);
         if (bus.busy !== 1'b1)  busy_bad  = 1'b1;
         if (bus.stall !== 1'b1) stall_bad = 1'b1;
         if (bus.done === 1'b1) begin
            lat = c;
            res = bus.result;
            check("result", bus.result, exp_res);
            check("result_dest", 32'(bus.result_dest), 32'(d));
         end
         @(posedge clk); #1;
      end
      check("latency",   32'(lat),       32'(exp_lat));
      check("busy_run",  32'(busy_bad),  32'd0);
      check("stall_run", 32'(stall_bad), 32'd0);
      if (lat != 0) exp_held = exp_res;
   endtask

   initial begin
      logic [31:0] r;
      int          base;
      logic [1:0]  ro;
      logic [4:0]  rs;

      // Reset state.
      reset = 1'b1;
      drive_idle();
      #1;
      check("rst_busy",   32'(bus.busy),        32'd0);
      check("rst_done",   32'(bus.done),        32'd0);
      check("rst_result", bus.result,           32'd0);
      check("rst_dest",   32'(bus.result_dest), 32'd0);
      check("rst_stall0", 32'(bus.stall),       32'd0);
      bus.start = 1'b1;
      #1;
      check("rst_stall1", 32'(bus.stall),       32'd1);
      bus.start = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // SLL 29 by 3.
      run_op(2'b00, 32'd29, 5'd3, 5'd2, r);
      check("tp_sll", r, 32'd232);

      // SRL then SRA back to back.
      run_op(2'b01, 32'd29, 5'd3, 5'd4, r);
      check("tp_srl", r, 32'd3);
      run_op(2'b10, 32'hFFFF_FF18, 5'd3, 5'd5, r);
      check("tp_sra", r, 32'hFFFF_FFE3);

      // Boundaries.
      run_op(2'b00, 32'h0000_1234, 5'd0, 5'd7, r);
      check("tp_shamt0", r, 32'h0000_1234);
      run_op(2'b00, 32'd1, 5'd31, 5'd8, r);
      check("tp_sll31", r, 32'h8000_0000);
      run_op(2'b10, 32'h8000_0000, 5'd31, 5'd9, r);
      check("tp_sra31", r, 32'hFFFF_FFFF);

      // Start during RUN is dropped.
      base = done_cnt;
      bus.start = 1'b1; bus.op = 2'b00; bus.operand = 32'd29; bus.shamt = 5'd3; bus.dest = 5'd2;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.operand = 32'd7; bus.shamt = 5'd1; bus.dest = 5'd3;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("ign_done_count", 32'(done_cnt - base), 32'd1);
      check("ign_result",     last_done_res,        32'd232);
      check("ign_dest",       last_done_dest,       32'd2);
      exp_held = 32'd232;

      // Flush in the second RUN cycle.
      base = done_cnt;
      bus.start = 1'b1; bus.op = 2'b00; bus.operand = 32'h55; bus.shamt = 5'd5; bus.dest = 5'd6;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      bus.flush = 1'b1;
      @(negedge clk);
      check("flush_done", 32'(bus.done), 32'd0);
      @(posedge clk); #1;
      bus.flush = 1'b0;
      @(negedge clk);
      check("flush_busy",   32'(bus.busy), 32'd0);
      check("flush_result", bus.result,    exp_held);
      repeat (8) @(posedge clk);
      #1;
      check("flush_no_done", 32'(done_cnt - base), 32'd0);

      // Start together with flush in IDLE.
      bus.start = 1'b1; bus.flush = 1'b1; bus.operand = 32'd9; bus.shamt = 5'd2;
      @(negedge clk);
      check("sf_stall", 32'(bus.stall), 32'd0);
      @(posedge clk); #1;
      bus.start = 1'b0; bus.flush = 1'b0;
      @(negedge clk);
      check("sf_busy", 32'(bus.busy), 32'd0);
      repeat (4) @(posedge clk);
      #1;
      check("sf_no_done", 32'(done_cnt - base), 32'd0);

      // Asynchronous reset mid-RUN.
      bus.start = 1'b1; bus.op = 2'b00; bus.operand = 32'd29; bus.shamt = 5'd3; bus.dest = 5'd2;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #2;
      reset = 1'b1;
      #1;
      check("arst_busy",   32'(bus.busy),        32'd0);
      check("arst_done",   32'(bus.done),        32'd0);
      check("arst_result", bus.result,           32'd0);
      check("arst_dest",   32'(bus.result_dest), 32'd0);
      exp_held = '0;
      @(posedge clk); #3;
      reset = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("arst_no_done", 32'(done_cnt - base), 32'd0);
      run_op(2'b00, 32'd29, 5'd3, 5'd2, r);
      check("arst_recover", r, 32'd232);

      // Randomized operations against the model.
      for (int i = 0; i < 30; i++) begin
         ro = 2'($urandom_range(0, 3));
         rs = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
         run_op(ro, $urandom, rs, 5'($urandom_range(0, 31)), r);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/mips32_shift_seq.md
# mips32_shift_seq

Multi-cycle shift sequencer for the MIPS32 pipelined processor. It performs logical-left, logical-right and arithmetic-right shifts one bit position per cycle, under a start/busy/done handshake. While a shift is in flight it drives a stall request that freezes the pipeline front end. It replaces the software add-and-branch shift loops, and exposes a flush input so a taken branch can cancel a speculative shift.

## Interface
- `WIDTH`, 32, operand/result width
- `SHAMT_W`, 5, shift-amount width (max shift `2**SHAMT_W-1`)
- `RTAG_W`, 5, destination register tag width
- `clk`  in  1  single system clock, rising-edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  request a shift; sampled only in IDLE
- `op`  in  2  00 SLL, 01 SRL, 10 SRA, 11 pass-through
- `operand`  in  WIDTH  value to shift
- `shamt`  in  SHAMT_W  shift amount
- `dest`  in  RTAG_W  destination register number, carried to output
- `flush`  in  1  cancel in-flight operation (taken branch)
- `busy`  out  1  high in any state other than IDLE
- `stall`  out  1  combinational `busy | (start & ~flush)`
- `done`  out  1  one-cycle pulse; result and tag valid
- `result`  out  WIDTH  shifted value, held until next `done`
- `result_dest`  out  RTAG_W  tag of `result`, held with it

## Operation
- States: IDLE, RUN, DONE.
- **IDLE:**
  - On `start & ~flush`, capture `operand` into the working register, `dest` into the tag register, `op`, and `shamt` into a down-counter.
  - If `shamt == 0` or `op == 11`, go to DONE; otherwise go to RUN.
- **RUN:**
  - Each cycle the working register shifts one bit:
    - SLL: `{w[WIDTH-2:0],0}`
    - SRL: `{0,w[WIDTH-1:1]}`
    - SRA: `{w[WIDTH-1],w[WIDTH-1:1]}`
  - The counter decrements each cycle. When the counter equals 1, the final shift happens and the state goes to DONE.
- **DONE:**
  - `done = 1`; `result` and `result_dest` are loaded from the working and tag registers.
  - Next state is IDLE unconditionally.
- **Start handling:**
  - `start` in RUN or DONE is ignored: not queued, no effect.
  - A new start is accepted in the cycle after DONE.
- **Flush:**
  - `flush` in RUN or DONE: next state is IDLE, and `done` is forced to 0 in that cycle.
  - `result` and `result_dest` keep their previous values.
  - `flush` and `start` together in IDLE: nothing is captured and the state stays IDLE.
- **Width rules:**
  - Bits shifted out are discarded; there is no overflow flag.
  - SRA of a negative value saturates at all-ones.
  - `shamt` is unsigned; a shift amount `>= WIDTH` is not representable.

## Timing
- **Reset (async, asserted):**
  - State IDLE; `busy = 0`, `done = 0`, `result = 0`, `result_dest = 0`.
  - Working register, tag register and counter are all 0.
  - `stall` follows its combinational equation.
- **Latency:** `start` accepted in cycle N gives `done` high in cycle N+1+shamt. For `op == 11`, `done` is high in cycle N+1.
- **`busy`:** high from cycle N+1 through the DONE cycle inclusive.
- **`stall`:** high from cycle N through the DONE cycle inclusive.
- **Back-to-back throughput:** one operation per shamt+2 cycles.
- **`done`:** exactly one cycle wide. `result` and `result_dest` change only on the edge that enters DONE, and are stable from the DONE cycle onward.
- **Reset mid-operation:** returns to IDLE immediately, with no `done` pulse.
- **Flush in cycle M during RUN:** `busy = 0` from cycle M+1.

## Test plan
- **SLL:** `op = 00`, `operand = 29`, `shamt = 3`, `dest = 2`, start at cycle N.
  - `done` at N+4 with `result = 232`, `result_dest = 2`.
  - `busy` high N+1..N+4.
- **SRL then SRA, back-to-back:**
  - `op = 01`, `operand = 29`, `shamt = 3` → `result = 3`.
  - Then `op = 10`, `operand = 0xFFFFFF18`, `shamt = 3`, started the cycle after the first `done` → `result = 0xFFFFFFE3`.
- **Boundaries:**
  - `shamt = 0`, `operand = 0x1234` → `done` at N+1 with `result = 0x1234`.
  - SLL of 1 by 31 → `done` at N+32 with `result = 0x80000000`.
  - SRA of `0x80000000` by 31 → `result = 0xFFFFFFFF`.
- **Ignored start:** `start` pulsed with `operand = 7` during RUN of a 29<<3 shift.
  - Only one `done` occurs, with `result = 232`.
  - The second request is dropped.
- **Flush:**
  - `flush` in the second RUN cycle → no `done`, `result` keeps its prior value, `busy = 0` the next cycle.
  - `start` and `flush` together in IDLE → `busy` stays 0.
- **Reset:** async `reset` asserted mid-RUN between clock edges.
  - Outputs go to reset values immediately, with no `done`.
  - After release, a new 29<<3 shift completes normally.
